// File: rtl/ahb_pkg.sv
// Shared AHB transfer, burst and response types plus a beats-per-burst helper.
// Declarations only: no state, no latency, no flow control.
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } transfer_t;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'd0,
        RESP_ERROR = 2'd1,
        RESP_RETRY = 2'd2,
        RESP_SPLIT = 2'd3
    } resp_t;

    // Undefined-length bursts (SINGLE/INCR) count as one beat: nothing to hold for.
    function automatic logic [4:0] burst_beats(input burst_t b);
        case (b)
            BURST_WRAP4,  BURST_INCR4:  burst_beats = 5'd4;
            BURST_WRAP8,  BURST_INCR8:  burst_beats = 5'd8;
            BURST_WRAP16, BURST_INCR16: burst_beats = 5'd16;
            default:                    burst_beats = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbiter bus bundle: master modport is the arbiter side, slave modport the fabric side.
// HSPLIT lane exists only when AHB_ARB_SPLIT_EN is defined.
import ahb_pkg::*;

interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    transfer_t              HTRANS;
    burst_t                 HBURST;
    logic                   HREADY;
    resp_t                  HRESP;
`ifdef AHB_ARB_SPLIT_EN
    logic [NUM_MASTERS-1:0] HSPLIT;
`endif
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [MW-1:0]          HMASTER;
    logic                   HMASTLOCK;

    modport master (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
`ifdef AHB_ARB_SPLIT_EN
        input  HSPLIT,
`endif
        output HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
`ifdef AHB_ARB_SPLIT_EN
        output HSPLIT,
`endif
        input  HGRANT, HMASTER, HMASTLOCK
    );

endinterface

// File: rtl/ahb_arb_picker.sv
// Combinational one-hot picker: first set request searching upward from start_i (rr) or from 0 (fixed).
// Zero latency; returns all-zero when nothing is requested.
module ahb_arb_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    input  logic          rr_mode_i,
    output logic [N-1:0]  gnt_o
);
    localparam int          IW1 = IW + 1;
    localparam logic [IW:0] NL  = IW1'(N);

    logic [IW:0] base;
    logic [IW:0] idx;
    logic        found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        base  = rr_mode_i ? {1'b0, start_i} : '0;
        for (int k = 0; k < N; k++) begin
            idx = base + IW1'(k);
            if (idx >= NL) idx = idx - NL;
            if (!found && req_i[idx[IW-1:0]]) begin
                gnt_o[idx[IW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB arbiter: fixed-priority/round-robin grant held across fixed bursts and locks; SPLIT masking with AHB_ARB_SPLIT_EN.
// HGRANT one edge after request, HMASTER one HREADY edge later; all outputs freeze while HREADY is low.
import ahb_pkg::*;

module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int ARB_MODE       = 1,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input logic           HCLK,
    input logic           HRESETn,
    ahb_arbiter_if.master bus
);
    localparam logic [1:0] ST_ARB    = 2'd0;
    localparam logic [1:0] ST_BURST  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [NUM_MASTERS-1:0] DEF_GNT = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
    localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic                   mastlock_q, mastlock_d;
    logic [3:0]             rem_q, rem_d;
    logic [MW-1:0]          last_q, last_d;
    logic [MW-1:0]          owner_idx, win_idx, start_idx;
    logic [1:0]             owner_state;
    logic [NUM_MASTERS-1:0] split_mask, cand, pick;

    always_comb begin
        owner_idx = '0;
        win_idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) owner_idx = MW'(i);
            if (pick[i])    win_idx   = MW'(i);
        end
    end

    // Any non-OKAY response abandons the burst, even during its wait-state cycle.
    always_comb begin
        rem_d = rem_q;
        if (bus.HRESP != RESP_OKAY) begin
            rem_d = '0;
        end else if (bus.HREADY) begin
            case (bus.HTRANS)
                TRANS_NONSEQ: rem_d = 4'(burst_beats(bus.HBURST) - 5'd1);
                TRANS_SEQ:    rem_d = (rem_q != 4'd0) ? rem_q - 4'd1 : 4'd0;
                default:      rem_d = rem_q;
            endcase
        end
    end

    // Release one beat early (rem_next == 1) so the next owner's NONSEQ follows the last address.
    always_comb begin
        if (bus.HLOCK[owner_idx])  owner_state = ST_LOCKED;
        else if (rem_d > 4'd1)     owner_state = ST_BURST;
        else                       owner_state = ST_ARB;
    end

`ifdef AHB_ARB_SPLIT_EN
    logic [NUM_MASTERS-1:0] split_q, split_d, split_set;

    always_comb begin
        split_set = '0;
        if (bus.HRESP == RESP_SPLIT && !bus.HREADY) split_set[hmaster_q] = 1'b1;
        split_d = (split_q & ~bus.HSPLIT) | split_set;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) split_q <= '0;
        else          split_q <= split_d;
    end

    assign split_mask = split_q;
`else
    assign split_mask = '0;
`endif

    assign cand      = bus.HBUSREQ & ~split_mask;
    assign start_idx = (last_q == MW'(NUM_MASTERS - 1)) ? '0 : last_q + 1'b1;

    ahb_arb_picker #(
        .N  (NUM_MASTERS),
        .IW (MW)
    ) u_picker (
        .req_i     (cand),
        .start_i   (start_idx),
        .rr_mode_i (ARB_MODE == 1),
        .gnt_o     (pick)
    );

    always_comb begin
        grant_d    = grant_q;
        last_d     = last_q;
        hmaster_d  = hmaster_q;
        mastlock_d = mastlock_q;
        if (bus.HREADY) begin
            hmaster_d  = owner_idx;
            mastlock_d = bus.HLOCK[owner_idx];
            if (owner_state == ST_ARB) begin
                if (|cand) begin
                    grant_d = pick;
                    last_d  = win_idx;
                end else begin
                    grant_d = DEF_GNT;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q    <= DEF_GNT;
            hmaster_q  <= DEF_IDX;
            mastlock_q <= 1'b0;
            rem_q      <= '0;
            last_q     <= DEF_IDX;
        end else begin
            grant_q    <= grant_d;
            hmaster_q  <= hmaster_d;
            mastlock_q <= mastlock_d;
            rem_q      <= rem_d;
            last_q     <= last_d;
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = hmaster_q;
    assign bus.HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter (4 masters, round-robin): directed scenarios then random traffic vs an integer reference model.
// Split scenarios run only when AHB_ARB_SPLIT_EN is defined.
import ahb_pkg::*;

module tb_ahb_arbiter;
    localparam int NM = 4;

    logic HCLK = 1'b0;
    logic HRESETn;

    always #5 HCLK = ~HCLK;

    ahb_arbiter_if #(.NUM_MASTERS(NM)) bus ();

    ahb_arbiter #(
        .NUM_MASTERS    (NM),
        .DEFAULT_MASTER (0),
        .ARB_MODE       (1)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    int          m_gnt, m_mst, m_last, m_rem;
    logic        m_lock;
    logic [NM-1:0] m_mask;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt  = 0;
        m_mst  = 0;
        m_lock = 1'b0;
        m_rem  = 0;
        m_last = 0;
        m_mask = '0;
    endtask

    function automatic int beats_of(input int b);
        return (b < 2) ? 1 : (4 << ((b - 2) / 2));
    endfunction

    // Advance the model one edge from the inputs currently driven, then compare after the edge.
    task automatic step();
        int            n_gnt, n_mst, n_last, n_rem, pos;
        logic          n_lock;
        logic [NM-1:0] n_mask, elig;
        bit            hold, found;
        n_gnt  = m_gnt;
        n_mst  = m_mst;
        n_last = m_last;
        n_rem  = m_rem;
        n_lock = m_lock;
        n_mask = m_mask;
        if (bus.HRESP != RESP_OKAY) n_rem = 0;
        else if (bus.HREADY) begin
            if (bus.HTRANS == TRANS_NONSEQ)              n_rem = beats_of(int'(bus.HBURST)) - 1;
            else if (bus.HTRANS == TRANS_SEQ && m_rem > 0) n_rem = m_rem - 1;
        end
        elig  = bus.HBUSREQ & ~m_mask;
        hold  = bus.HLOCK[m_gnt] || (n_rem > 1);
        found = 1'b0;
        if (bus.HREADY && !hold) begin
            n_gnt = 0;
            for (int k = 1; k <= NM; k++) begin
                pos = (m_last + k) % NM;
                if (!found && elig[pos]) begin
                    n_gnt  = pos;
                    n_last = pos;
                    found  = 1'b1;
                end
            end
        end
        if (bus.HREADY) begin
            n_mst  = m_gnt;
            n_lock = bus.HLOCK[m_gnt];
        end
`ifdef AHB_ARB_SPLIT_EN
        n_mask = m_mask & ~bus.HSPLIT;
        if (bus.HRESP == RESP_SPLIT && !bus.HREADY) n_mask[m_mst] = 1'b1;
`endif
        @(posedge HCLK);
        #1;
        m_gnt  = n_gnt;
        m_mst  = n_mst;
        m_last = n_last;
        m_rem  = n_rem;
        m_lock = n_lock;
        m_mask = n_mask;
        check("hgrant", 32'(bus.HGRANT), 32'd1 << m_gnt);
        check("hmaster", 32'(bus.HMASTER), 32'(m_mst));
        check("hmastlock", 32'(bus.HMASTLOCK), 32'(m_lock));
    endtask

    task automatic drive(input logic [NM-1:0] req, input logic [NM-1:0] lock, input transfer_t tr,
                         input burst_t bu, input logic rdy, input resp_t rs, input logic [NM-1:0] hs);
        bus.HBUSREQ = req;
        bus.HLOCK   = lock;
        bus.HTRANS  = tr;
        bus.HBURST  = bu;
        bus.HREADY  = rdy;
        bus.HRESP   = rs;
`ifdef AHB_ARB_SPLIT_EN
        bus.HSPLIT  = hs;
`endif
        step();
    endtask

    task automatic reset_mid(input string tag);
        #2 HRESETn = 1'b0;
        #1;
        model_reset();
        check({tag, "_gnt"}, 32'(bus.HGRANT), 32'h1);
        check({tag, "_mst"}, 32'(bus.HMASTER), 32'h0);
        check({tag, "_lock"}, 32'(bus.HMASTLOCK), 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    // Request only from `who` until granted, then one more edge so HMASTER follows.
    task automatic own(input int who);
        logic [NM-1:0] r;
        r = NM'(1) << who;
        for (int k = 0; k < 8 && m_gnt != who; k++)
            drive(r, '0, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, '0);
        drive(r, '0, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, '0);
        check("own_master", 32'(bus.HMASTER), 32'(who));
    endtask

    task automatic burst_test(input int stall);
        own(1);
        drive(4'b0110, '0, TRANS_NONSEQ, BURST_INCR4, 1'b1, RESP_OKAY, '0);
        check("burst_e0_gnt", 32'(bus.HGRANT), 32'b0010);
        drive(4'b0110, '0, TRANS_SEQ, BURST_INCR4, 1'b1, RESP_OKAY, '0);
        check("burst_e1_gnt", 32'(bus.HGRANT), 32'b0010);
        for (int s = 0; s < stall; s++) begin
            drive(4'b0110, '0, TRANS_SEQ, BURST_INCR4, 1'b0, RESP_OKAY, '0);
            check("stall_gnt", 32'(bus.HGRANT), 32'b0010);
            check("stall_mst", 32'(bus.HMASTER), 32'd1);
        end
        drive(4'b0110, '0, TRANS_SEQ, BURST_INCR4, 1'b1, RESP_OKAY, '0);
        check("burst_e2_gnt", 32'(bus.HGRANT), 32'b0100);
        check("burst_e2_mst", 32'(bus.HMASTER), 32'd1);
        drive(4'b0100, '0, TRANS_SEQ, BURST_INCR4, 1'b1, RESP_OKAY, '0);
        check("burst_e3_mst", 32'(bus.HMASTER), 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        HRESETn     = 1'b0;
        bus.HBUSREQ = '0;
        bus.HLOCK   = '0;
        bus.HTRANS  = TRANS_IDLE;
        bus.HBURST  = BURST_SINGLE;
        bus.HREADY  = 1'b1;
        bus.HRESP   = RESP_OKAY;
`ifdef AHB_ARB_SPLIT_EN
        bus.HSPLIT  = '0;
`endif
        model_reset();
        repeat (2) @(posedge HCLK);
        #1;
        check("reset_gnt", 32'(bus.HGRANT), 32'b0001);
        check("reset_mst", 32'(bus.HMASTER), 32'd0);
        check("reset_lock", 32'(bus.HMASTLOCK), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        for (int k = 0; k < 8; k++) begin
            drive(4'b1111, '0, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, '0);
            check("rr_gnt", 32'(bus.HGRANT), 32'd1 << ((k + 1) % NM));
        end

        burst_test(0);
        burst_test(3);

        for (int k = 0; k < 8 && m_gnt != 3; k++)
            drive(4'b1111, 4'b1000, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, '0);
        for (int k = 0; k < 2; k++) begin
            drive(4'b1111, 4'b1000, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, '0);
            check("lock_gnt", 32'(bus.HGRANT), 32'b1000);
            check("lock_mastlock", 32'(bus.HMASTLOCK), 32'd1);
        end
        drive(4'b1111, 4'b0000, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, '0);
        check("unlock_gnt", 32'(bus.HGRANT), 32'b0001);

`ifdef AHB_ARB_SPLIT_EN
        own(1);
        drive(4'b0110, '0, TRANS_NONSEQ, BURST_SINGLE, 1'b0, RESP_SPLIT, '0);
        check("split_hold_gnt", 32'(bus.HGRANT), 32'b0010);
        drive(4'b0110, '0, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_SPLIT, '0);
        check("split_skip_gnt", 32'(bus.HGRANT), 32'b0100);
        drive(4'b0010, '0, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, '0);
        check("split_default_gnt", 32'(bus.HGRANT), 32'b0001);
        drive(4'b0010, '0, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 4'b0010);
        check("split_release_gnt", 32'(bus.HGRANT), 32'b0001);
        drive(4'b0010, '0, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, '0);
        check("split_regrant_gnt", 32'(bus.HGRANT), 32'b0010);
`endif

        for (int n = 0; n < 1500; n++) begin
            logic [NM-1:0] lk, hs;
            lk = '0;
            hs = '0;
            for (int b = 0; b < NM; b++) begin
                lk[b] = ($urandom_range(0, 7) == 0);
                hs[b] = ($urandom_range(0, 5) == 0);
            end
            drive(NM'($urandom_range(0, 15)), lk,
                  transfer_t'(2'($urandom_range(0, 3))),
                  burst_t'(3'($urandom_range(0, 7))),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0) ? resp_t'(2'($urandom_range(1, 3))) : RESP_OKAY,
                  hs);
            if (n == 700 || n == 1200) reset_mid("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Parametrised AHB bus arbiter for NUM_MASTERS masters sharing one AHB bus, with selectable fixed-priority or round-robin arbitration. It samples per-master HBUSREQ/HLOCK, tracks the active transfer on the shared HTRANS/HBURST/HREADY/HRESP, and drives one-hot HGRANT plus HMASTER/HMASTLOCK to the address/data muxes and slaves. It holds grant across fixed-length bursts and locked sequences. Optionally, it supports SPLIT masking.

## Interface
- NUM_MASTERS, 4: number of masters, 2..16
- DEFAULT_MASTER, 0: index granted when no eligible request
- ARB_MODE, 1: 0 = fixed priority (lowest index wins), 1 = round-robin
- MW, $clog2(NUM_MASTERS): HMASTER width (derived)

Ports:
- HCLK  in  1  bus clock; all state updates on rising edge
- HRESETn  in  1  reset; asynchronous, active-low
- HBUSREQ  in  NUM_MASTERS  per-master bus request
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request
- HTRANS  in  2  transfer type of current bus owner (transfer_t)
- HBURST  in  3  burst type of current bus owner
- HREADY  in  1  shared transfer-done
- HRESP  in  2  shared slave response (resp_t)
- HSPLIT  in  NUM_MASTERS  split-release per master (only with AHB_ARB_SPLIT_EN)
- HGRANT  out  NUM_MASTERS  one-hot grant, registered
- HMASTER  out  MW  index of address-phase owner, registered
- HMASTLOCK  out  1  current address phase is locked, registered

## Operation
- Reset values: HGRANT = one-hot(DEFAULT_MASTER), HMASTER = DEFAULT_MASTER, HMASTLOCK = 0, rem = 0, last = DEFAULT_MASTER, split mask = 0.
- Burst counter rem (4 bits), updated on HREADY=1:
  - NONSEQ loads 3/7/15 for INCR4|WRAP4 / INCR8|WRAP8 / INCR16|WRAP16.
  - NONSEQ loads 0 for SINGLE/INCR.
  - SEQ decrements, saturating at 0.
  - IDLE/BUSY leave rem unchanged.
- Any cycle with HRESP != OKAY forces rem = 0, regardless of HREADY.
- States, held in the 2-bit owner state:
  - ARB: grant may change.
  - BURST: rem_next > 1, hold.
  - LOCKED: HLOCK[owner] = 1, hold.
  - LOCKED takes precedence over BURST.
- Update rule: on each HREADY=1 edge not in hold, HGRANT <= winner.
- Winner selection:
  - Candidates are HBUSREQ & ~split_mask. If no candidate, the winner is DEFAULT_MASTER.
  - ARB_MODE=0: lowest index wins.
  - ARB_MODE=1: search starts at (last+1) mod NUM_MASTERS. last updates only when a requesting master is granted.
- On every HREADY=1 edge: HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[index(HGRANT)].
- HREADY=0: HGRANT, HMASTER, HMASTLOCK and rem hold. The only exception is the HRESP rule for rem.
- Owner dropping HBUSREQ mid fixed burst: grant is still held until rem_next <= 1.

## Timing
- Grant latency: request at edge N, where N is the first HREADY=1 edge with no hold, gives HGRANT at N+1. HMASTER follows at the next HREADY=1 edge.
- 4-beat burst timing:
  - NONSEQ accepted at edge E0, then SEQs at E1, E2, E3.
  - HGRANT may change at E2, when rem becomes 1.
  - HMASTER changes at E3, so the new master drives NONSEQ right after the last address.
- Locked release: HLOCK deasserts at cycle C; grant may change at the first HREADY=1 edge at or after C+1.
- Reset mid-burst returns all state to reset values immediately; the burst is abandoned.

## Configuration
- AHB_ARB_SPLIT_EN defined:
  - HSPLIT port present.
  - First cycle of SPLIT response (HRESP=SPLIT, HREADY=0) sets split_mask[HMASTER].
  - HSPLIT[i]=1 clears split_mask[i]. Simultaneous set and clear of the same bit: set wins.
  - Masked masters are ineligible until cleared.
- Not defined: no HSPLIT port and no mask; SPLIT is handled exactly like RETRY.

## Structure
- Shared ahb_pkg holds:
  - transfer_t (IDLE, BUSY, NONSEQ, SEQ)
  - the burst enum (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16)
  - resp_t (OKAY, ERROR, RETRY, SPLIT)
  - a beats-per-burst constant function
- Sub-module ahb_arb_picker: combinational one-hot picker taking a request vector, start index and mode. The top holds all state.

## Test plan
- Reset asserted mid-traffic -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0 within the same cycle.
- ARB_MODE=1, HBUSREQ=4'b1111, SINGLE NONSEQs, HREADY=1 -> HGRANT rotates 0001→0010→0100→1000→0001 each cycle.
- Master 1 INCR4 while master 2 requests -> HGRANT=0010 through E1, 0100 at E2; HMASTER=2 at E3.
- Same burst with HREADY=0 for 3 cycles after E1 -> HGRANT, HMASTER and rem frozen; switch is delayed by 3 cycles.
- HLOCK[3]=1, HBUSREQ=1111 -> HGRANT=1000 and HMASTLOCK=1 while locked; HLOCK drops -> grant moves to master 0 at next HREADY edge.
- SPLIT_EN: master 1 receives SPLIT -> master 1 skipped despite HBUSREQ[1]=1; HSPLIT[1] pulse -> master 1 granted on the next eligible edge.
